sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Parametrised successor to the team's fixed 8-bit × 4-entry synchronous FIFO, sitting between a producer and a consumer on one clock domain.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, and a synchronous flush.
- Adds sticky overflow/underflow error flags and accepts an enqueue while full when a dequeue happens in the same cycle.
- Drop-in for producer/consumer test rigs; the existing handshake names are kept.

Parameters:
- WIDTH, 8, data bits per entry (≥1).
- DEPTH, 4, number of entries; power of 2, ≥2.
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous empty request; does not clear error flags.
- enqueue_request  in  1  producer offers data_in this cycle.
- dequeue_request  in  1  consumer takes data_out this cycle.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  head entry; valid only while !is_empty.
- is_empty  out  1  registered; count==0.
- is_full  out  1  registered; count==DEPTH.
- almost_empty  out  1  registered; count ≤ AE_LEVEL.
- almost_full  out  1  registered; count ≥ AF_LEVEL.
- count  out  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
- overflow  out  1  sticky: an enqueue was rejected.
- underflow  out  1  sticky: a dequeue was rejected.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - Pointers = 0, count = 0, is_empty = 1, is_full = 0, almost_empty = 1.
  - almost_full = (AF_LEVEL==0 ? 1 : 0), which is 0 for legal values.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset; data_out is undefined while empty.
- Pointers:
  - Write and read pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Both pointers wrap naturally at 2·DEPTH.
- Acceptance (computed from the current registered state):
  - do_dequeue = dequeue_request && !is_empty.
  - do_enqueue = enqueue_request && (!is_full || do_dequeue).
  - When full, a simultaneous enqueue and dequeue are both accepted: count stays DEPTH, the head advances, and the new word is written into the freed slot.
  - When empty, a simultaneous enqueue and dequeue: the dequeue is rejected, the enqueue is accepted, and count becomes 1.
- Latency:
  - A written word is visible on data_out the cycle after the write when the FIFO was empty (first-word fall-through, combinational read of the head entry).
  - is_empty deasserts in that same cycle.
  - data_out changes to the next entry the cycle after an accepted dequeue.
- Flags and count:
  - All flags and count are registered and derived from the next-state pointers, so they are never one cycle stale.
  - count_next = count + do_enqueue − do_dequeue, held in a register, not recomputed from the pointers at the output.
- Errors:
  - overflow sets on the cycle after enqueue_request && !do_enqueue.
  - underflow sets on the cycle after dequeue_request && is_empty.
  - Both hold until reset; flush does not clear them.
  - Rejected requests never move the pointers.
- Flush:
  - Next cycle: pointers = 0, count = 0, flags take their reset values except the error flags.
  - flush has priority over enqueue and dequeue in the same cycle; both are discarded without setting the error flags.
- reset has priority over flush and over all traffic.
- Reset mid-stream drops all contents; the outputs meet the reset values on the cycle after reset is sampled high.
- Sustained traffic: throughput is 1 word per cycle with simultaneous enqueue and dequeue at any occupancy from 1 to DEPTH.

Decomposition:
- Shared package: a pointer-width helper, PTR_W = $clog2(DEPTH)+1, plus parameter-legality checks (DEPTH power of 2, AF/AE ranges) as elaboration-time assertions.
- One sub-module is natural: fifo_mem, a WIDTH×DEPTH register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stays in sync_fifo_flags.

Test Plan:
- WIDTH=8, DEPTH=4: reset, then enqueue 0x00..0x03 on 4 consecutive cycles.
  - count goes 1,2,3,4; almost_full at count=3; is_full after the 4th.
  - data_out = 0x00 from cycle 1.
- Full FIFO holding 00..03: assert enqueue(0x04) and dequeue together.
  - Both accepted, count stays 4, overflow stays 0.
  - Draining yields 01,02,03,04.
- Full FIFO: enqueue 0xAA alone → overflow=1 next cycle, count=4, 0xAA is never dequeued.
- Empty FIFO: dequeue alone → underflow=1, count=0.
  - Then enqueue 0x55 together with dequeue → count=1, data_out=0x55.
- Count=3 with almost_empty=0: pulse flush together with enqueue.
  - Next cycle count=0, is_empty=1, almost_empty=1, overflow and underflow unchanged.
- Sustained streaming: wrap pointers at least 3 times (≥24 words) with random stalls on both sides.
  - Scoreboard matches in order; count is never >4 or <0; no error flags set.

Source files
------------

// File: rtl/sync_fifo_flags_pkg.sv
// Shared helpers for sync_fifo_flags: pointer width and parameter legality tests.
package sync_fifo_flags_pkg;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module sync_fifo_flags_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush and sticky errors.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      enqueue_request,
  input  logic                      dequeue_request,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      is_empty,
  output logic                      is_full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be at least 1");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic             r_is_empty, r_is_full, r_almost_empty, r_almost_full;
  logic             r_overflow, r_underflow;

  logic             w_do_enq, w_do_deq, w_wr_en;
  logic [PTR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic             w_ovf_nxt, w_udf_nxt;

  // A dequeue frees a slot in the same cycle, so a full FIFO may still accept a write.
  assign w_do_deq = dequeue_request && !r_is_empty;
  assign w_do_enq = enqueue_request && (!r_is_full || w_do_deq);
  assign w_wr_en  = w_do_enq && !flush && !reset;

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_ovf_nxt    = r_overflow;
    w_udf_nxt    = r_underflow;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_do_enq);
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_deq);
      w_count_nxt  = r_count + PTR_W'(w_do_enq) - PTR_W'(w_do_deq);
      w_ovf_nxt    = r_overflow  | (enqueue_request & ~w_do_enq);
      w_udf_nxt    = r_underflow | (dequeue_request & r_is_empty);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_is_empty     <= 1'b1;
      r_is_full      <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= (AF_LEVEL == 0);
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_is_empty     <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_is_full      <= ((w_wr_ptr_nxt ^ w_rd_ptr_nxt) == {1'b1, {AW{1'b0}}});
      r_almost_empty <= (w_count_nxt <= PTR_W'(AE_LEVEL));
      r_almost_full  <= (w_count_nxt >= PTR_W'(AF_LEVEL));
      r_overflow     <= w_ovf_nxt;
      r_underflow    <= w_udf_nxt;
    end
  end

  sync_fifo_flags_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (data_out)
  );

  assign is_empty     = r_is_empty;
  assign is_full      = r_is_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed and randomized bench for sync_fifo_flags (WIDTH=8, DEPTH=4) against a queue model.
module tb_sync_fifo_flags;

  localparam int DEPTH = 4;
  localparam int AE    = 1;
  localparam int AF    = DEPTH - 1;

  logic       clk = 1'b0;
  logic       reset, flush, enqueue_request, dequeue_request;
  logic [7:0] data_in, data_out;
  logic       is_empty, is_full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;

  sync_fifo_flags #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .enqueue_request (enqueue_request),
    .dequeue_request (dequeue_request),
    .data_in         (data_in),
    .data_out        (data_out),
    .is_empty        (is_empty),
    .is_full         (is_full),
    .almost_empty    (almost_empty),
    .almost_full     (almost_full),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pushed = 0;
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a FIFO queue plus two sticky error bits.
  task automatic model_update(input bit rst, input bit fl, input bit enq, input bit deq,
                              input logic [7:0] din);
    bit deq_ok, enq_ok;
    logic [7:0] popped;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (fl) begin
      q.delete();
    end else begin
      deq_ok = deq && (q.size() != 0);
      enq_ok = enq && ((q.size() < DEPTH) || deq_ok);
      if (deq && q.size() == 0) m_udf = 1'b1;
      if (enq && !enq_ok)       m_ovf = 1'b1;
      if (deq_ok) popped = q.pop_front();
      if (enq_ok) begin
        q.push_back(din);
        n_pushed++;
      end
    end
  endtask

  task automatic check_outputs();
    check("count",        32'(count),        32'(q.size()));
    check("is_empty",     32'(is_empty),     32'(q.size() == 0));
    check("is_full",      32'(is_full),      32'(q.size() == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
    if (q.size() != 0) check("data_out", 32'(data_out), 32'(q[0]));
  endtask

  task automatic step(input bit rst, input bit fl, input bit enq, input bit deq,
                      input logic [7:0] din);
    reset           = rst;
    flush           = fl;
    enqueue_request = enq;
    dequeue_request = deq;
    data_in         = din;
    @(posedge clk);
    model_update(rst, fl, enq, deq, din);
    #1;
    check_outputs();
  endtask

  initial begin
    bit enq_r, deq_r;
    int cycles;
    reset = 1'b1; flush = 1'b0; enqueue_request = 1'b0; dequeue_request = 1'b0; data_in = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 8'h00);
    check("reset_af", 32'(almost_full), 32'h0);

    // Fill 00..03; first word must fall through after one cycle.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 8'(i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fall_through", 32'(data_out), 32'h00);
    end
    check("full_after_fill", 32'(is_full), 32'h1);

    // Full plus simultaneous enqueue/dequeue.
    step(0, 0, 1, 1, 8'h04);
    check("full_simul_count", 32'(count), 32'h4);
    check("full_simul_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(data_out), 32'(i + 1));
      step(0, 0, 0, 1, 8'h00);
    end

    // Overflow on a full FIFO.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 8'(8'h10 + i));
    step(0, 0, 1, 0, 8'hAA);
    check("ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      check("no_aa", 32'(data_out != 8'hAA), 32'h1);
      step(0, 0, 0, 1, 8'h00);
    end

    // Underflow, then enqueue+dequeue on empty.
    step(0, 0, 0, 1, 8'h00);
    check("udf_set", 32'(underflow), 32'h1);
    step(0, 0, 1, 1, 8'h55);
    check("empty_simul_count", 32'(count), 32'h1);
    check("empty_simul_data", 32'(data_out), 32'h55);

    // Flush wins over a same-cycle enqueue and keeps the error flags.
    step(0, 0, 1, 0, 8'h66);
    step(0, 0, 1, 0, 8'h67);
    check("pre_flush_ae", 32'(almost_empty), 32'h0);
    step(0, 1, 1, 0, 8'h77);
    check("flush_count", 32'(count), 32'h0);
    check("flush_keeps_ovf", 32'(overflow), 32'h1);
    check("flush_keeps_udf", 32'(underflow), 32'h1);

    // Reset with contents drops them and clears the error flags.
    step(0, 0, 1, 0, 8'h21);
    step(0, 0, 1, 0, 8'h22);
    step(1, 0, 1, 1, 8'h23);
    check("midreset_empty", 32'(is_empty), 32'h1);
    check("midreset_ovf", 32'(overflow), 32'h0);

    // Randomized streaming with stalls on both sides.
    n_pushed = 0;
    cycles   = 0;
    while (n_pushed < 32 && cycles < 2000) begin
      deq_r = ($urandom_range(0, 3) != 0) && (q.size() != 0);
      enq_r = ($urandom_range(0, 3) != 0) && ((q.size() < DEPTH) || deq_r);
      step(0, 0, enq_r, deq_r, 8'($urandom));
      cycles++;
    end
    check("stream_words_reached", 32'(n_pushed >= 32), 32'h1);
    cycles = 0;
    while (q.size() != 0 && cycles < 20) begin
      step(0, 0, 0, 1, 8'h00);
      cycles++;
    end
    check("stream_drained", 32'(is_empty), 32'h1);
    check("stream_no_ovf", 32'(overflow), 32'h0);
    check("stream_no_udf", 32'(underflow), 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
